// File: rtl/cpu_defines.sv
// Shared CPU definitions: CP0 register map, write masks, Status/Cause field
// positions and exception codes used by the coprocessor-0 exception unit.
package cpu_defines;

   localparam logic [4:0] CP0_REG_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_REG_WIRED    = 5'd6;
   localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
   localparam logic [4:0] CP0_REG_ENTRYHI  = 5'd10;
   localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_REG_EPC      = 5'd14;
   localparam logic [4:0] CP0_REG_PRID     = 5'd15;

   localparam logic [2:0] CP0_SEL_0     = 3'd0;
   localparam logic [2:0] CP0_SEL_EBASE = 3'd1;

   localparam logic [31:0] STATUS_WMASK  = 32'h1040_FF07;
   localparam logic [31:0] CAUSE_WMASK   = 32'h0000_0300;
   localparam logic [31:0] EBASE_WMASK   = 32'h3FFF_F000;
   localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;

   localparam logic [31:0] PRID_VALUE      = 32'h0001_8000;
   localparam logic [31:0] VEC_BEV_BASE    = 32'hBFC0_0200;
   localparam logic [31:0] VEC_GENERAL_OFS = 32'h0000_0180;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_ERL    = 2;
   localparam int ST_IM_LO  = 8;
   localparam int ST_BEV    = 22;

   localparam int CA_BD     = 31;
   localparam int CA_TI     = 30;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_MOD  = 5'd1,
      EXC_TLBL = 5'd2,
      EXC_TLBS = 5'd3,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // TLB and address-error exceptions report the faulting address.
   function automatic logic loads_badvaddr(input logic [4:0] code);
      return (code >= EXC_MOD) && (code <= EXC_ADES);
   endfunction

   // Only TLB exceptions also capture the faulting VPN into EntryHi.
   function automatic logic loads_entryhi(input logic [4:0] code);
      return (code >= EXC_MOD) && (code <= EXC_TLBS);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and the sticky
// timer-interrupt flag that feeds Cause.TI.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [PW-1:0] presc_q;
   logic [31:0]   count_q;
   logic [31:0]   compare_q;
   logic          ti_q;
   logic          tick;
   logic [31:0]   count_inc;

   assign tick      = (presc_q == PW'(COUNT_DIV - 1));
   assign count_inc = count_q + 32'd1;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         if (count_we) begin
            count_q <= wdata;
            presc_q <= '0;
         end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) count_q <= count_inc;
         end

         if (compare_we) compare_q <= wdata;

         // TI is sticky: only a Compare write acknowledges it.
         if (compare_we)
            ti_q <= 1'b0;
         else if (!count_we && tick && (count_inc == compare_q))
            ti_q <= 1'b1;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// MIPS32 coprocessor-0 register file and exception unit: MTC0/MFC0 access,
// exception entry, ERET, Random/Wired, exception vector and interrupt request.
module cp0_exc_unit
   import cpu_defines::*;
#(
   parameter int          TLB_ENTRY_NUM = 16,
   parameter int          HW_INT_NUM    = 6,
   parameter int          COUNT_DIV     = 2,
   parameter logic [31:0] STATUS_RESET  = 32'h0040_0004,
   parameter logic [31:0] EBASE_RESET   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [2:0]            wsel_i,
   input  logic [31:0]           wdata_i,
   input  logic [4:0]            raddr_i,
   input  logic [2:0]            rsel_i,
   output logic [31:0]           data_o,
   input  logic [HW_INT_NUM-1:0] int_i,
   input  logic                  excp_valid_i,
   input  logic [4:0]            excp_code_i,
   input  logic                  tlb_refill_i,
   input  logic                  eret_i,
   input  logic [31:0]           pc_i,
   input  logic                  in_delayslot_i,
   input  logic [31:0]           bad_vaddr_i,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic [31:0]           ebase_o,
   output logic [31:0]           entryhi_o,
   output logic [31:0]           random_o,
   output logic [31:0]           wired_o,
   output logic [31:0]           exc_vector_o,
   output logic                  int_req_o
);

   localparam int          RW         = $clog2(TLB_ENTRY_NUM);
   localparam logic [RW-1:0] RANDOM_TOP = RW'(TLB_ENTRY_NUM - 1);

   logic [31:0]           status_q, epc_q, ebase_q, entryhi_q, badvaddr_q;
   logic [RW-1:0]         random_q, wired_q;
   logic                  bd_q;
   logic [4:0]            exc_code_q;
   logic [1:0]            ip_sw_q;
   logic [HW_INT_NUM-1:0] ip_hw_q;
   logic                  int_req_q;

   logic [31:0] count, compare;
   logic        ti;
   logic [7:0]  cause_ip;
   logic [31:0] vec_base;
   logic        int_req_next;

   // An exception in the same cycle swallows the MTC0.
   logic mtc0_en, wr_sel0;
   logic wr_status, wr_cause, wr_epc, wr_ebase, wr_entryhi, wr_wired, wr_count, wr_compare;

   assign mtc0_en    = we_i && !excp_valid_i;
   assign wr_sel0    = mtc0_en && (wsel_i == CP0_SEL_0);
   assign wr_status  = wr_sel0 && (waddr_i == CP0_REG_STATUS);
   assign wr_cause   = wr_sel0 && (waddr_i == CP0_REG_CAUSE);
   assign wr_epc     = wr_sel0 && (waddr_i == CP0_REG_EPC);
   assign wr_entryhi = wr_sel0 && (waddr_i == CP0_REG_ENTRYHI);
   assign wr_wired   = wr_sel0 && (waddr_i == CP0_REG_WIRED);
   assign wr_count   = wr_sel0 && (waddr_i == CP0_REG_COUNT);
   assign wr_compare = wr_sel0 && (waddr_i == CP0_REG_COMPARE);
   assign wr_ebase   = mtc0_en && (wsel_i == CP0_SEL_EBASE) && (waddr_i == CP0_REG_PRID);

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (wdata_i),
      .count_o    (count),
      .compare_o  (compare),
      .ti_o       (ti)
   );

   // NOTE: every variable driven here gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      cause_ip      = '0;
      cause_ip[1:0] = ip_sw_q;
      for (int i = 0; i < HW_INT_NUM; i++) cause_ip[2+i] = ip_hw_q[i];
      cause_ip[7]   = cause_ip[7] | ti;
   end

   assign cause_o = {bd_q, ti, 14'b0, cause_ip, 1'b0, exc_code_q, 2'b0};

   assign int_req_next = status_q[ST_IE] && !status_q[ST_EXL] && !status_q[ST_ERL] &&
                         |(cause_ip & status_q[ST_IM_LO +: 8]);

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= STATUS_RESET;
         ebase_q    <= EBASE_RESET;
         random_q   <= RANDOM_TOP;
         wired_q    <= '0;
         epc_q      <= '0;
         entryhi_q  <= '0;
         badvaddr_q <= '0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
         int_req_q  <= 1'b0;
      end else begin
         ip_hw_q   <= int_i;
         int_req_q <= int_req_next;

         if (wr_wired || (random_q <= wired_q)) random_q <= RANDOM_TOP;
         else                                   random_q <= random_q - RW'(1);
         if (wr_wired) wired_q <= wdata_i[RW-1:0];

         if (excp_valid_i)                status_q[ST_EXL] <= 1'b1;
         else if (eret_i && status_q[ST_ERL]) status_q[ST_ERL] <= 1'b0;
         else if (eret_i)                 status_q[ST_EXL] <= 1'b0;
         else if (wr_status)
            status_q <= (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);

         // A nested exception keeps the EPC/BD of the outermost one.
         if (excp_valid_i) begin
            exc_code_q <= excp_code_i;
            if (!status_q[ST_EXL]) begin
               epc_q <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
               bd_q  <= in_delayslot_i;
            end
         end else begin
            if (wr_cause) ip_sw_q <= wdata_i[9:8];
            if (wr_epc)   epc_q   <= wdata_i;
         end

         if (excp_valid_i && loads_badvaddr(excp_code_i)) badvaddr_q <= bad_vaddr_i;

         if (excp_valid_i && loads_entryhi(excp_code_i))
            entryhi_q[31:13] <= bad_vaddr_i[31:13];
         else if (wr_entryhi)
            entryhi_q <= (entryhi_q & ~ENTRYHI_WMASK) | (wdata_i & ENTRYHI_WMASK);

         if (wr_ebase) ebase_q <= (ebase_q & ~EBASE_WMASK) | (wdata_i & EBASE_WMASK);
      end
   end

   always_comb begin
      data_o = '0;
      if (rsel_i == CP0_SEL_0) begin
         case (raddr_i)
            CP0_REG_RANDOM:   data_o = random_o;
            CP0_REG_WIRED:    data_o = wired_o;
            CP0_REG_BADVADDR: data_o = badvaddr_q;
            CP0_REG_COUNT:    data_o = count;
            CP0_REG_ENTRYHI:  data_o = entryhi_q;
            CP0_REG_COMPARE:  data_o = compare;
            CP0_REG_STATUS:   data_o = status_q;
            CP0_REG_CAUSE:    data_o = cause_o;
            CP0_REG_EPC:      data_o = epc_q;
            CP0_REG_PRID:     data_o = PRID_VALUE;
            default:          data_o = '0;
         endcase
      end else if ((rsel_i == CP0_SEL_EBASE) && (raddr_i == CP0_REG_PRID)) begin
         data_o = ebase_q;
      end
   end

   assign vec_base     = status_q[ST_BEV] ? VEC_BEV_BASE : ebase_q;
   assign exc_vector_o = (tlb_refill_i && !status_q[ST_EXL]) ? vec_base
                                                             : vec_base + VEC_GENERAL_OFS;

   assign status_o  = status_q;
   assign epc_o     = epc_q;
   assign ebase_o   = ebase_q;
   assign entryhi_o = entryhi_q;
   assign random_o  = 32'(random_q);
   assign wired_o   = 32'(wired_q);
   assign int_req_o = int_req_q;

endmodule
